// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/redirect controller.
// Includes FSM states, operand forwarding selects and the stage-match helper.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // $0 is hardwired zero, so a write to it never produces a forwardable value.
  function automatic logic stage_hit(input logic we, input logic [4:0] wadr, input logic [4:0] radr);
    return we && (wadr == radr) && (radr != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_redirect_controller_if.sv
// ID-stage operand/hazard inputs and the stall, flush, forward and counter outputs.
// master = pipeline datapath side, slave = controller.
interface hazard_redirect_controller_if #(parameter int CNT_W = 32);
  logic [4:0]       R1Adr;
  logic [4:0]       R2Adr;
  logic             R1Used;
  logic             R2Used;
  logic [4:0]       EX_WAdr;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [4:0]       MEM_WAdr;
  logic             MEM_RegWrite;
  logic [4:0]       WB_WAdr;
  logic             WB_RegWrite;
  logic             Redirect;
  logic             Halt;
  logic             Go;
  logic [1:0]       R1_Fwd;
  logic [1:0]       R2_Fwd;
  logic             Stall_PC_ID;
  logic             Flush_IF_ID;
  logic             Flush_ID_EX;
  logic             Halted;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output R1Adr, R2Adr, R1Used, R2Used, EX_WAdr, EX_RegWrite, EX_MemRead,
           MEM_WAdr, MEM_RegWrite, WB_WAdr, WB_RegWrite, Redirect, Halt, Go,
    input  R1_Fwd, R2_Fwd, Stall_PC_ID, Flush_IF_ID, Flush_ID_EX, Halted,
           StallCnt, FlushCnt
  );

  modport slave (
    input  R1Adr, R2Adr, R1Used, R2Used, EX_WAdr, EX_RegWrite, EX_MemRead,
           MEM_WAdr, MEM_RegWrite, WB_WAdr, WB_RegWrite, Redirect, Halt, Go,
    output R1_Fwd, R2_Fwd, Stall_PC_ID, Flush_IF_ID, Flush_ID_EX, Halted,
           StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_redirect_controller_fwd_select.sv
// Picks the youngest in-flight producer of one ID operand (EX > MEM > WB > regfile).
// Purely combinational, zero latency; no backpressure.
module fwd_select
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] rd_adr,
  input  logic       ex_we,
  input  logic [4:0] ex_adr,
  input  logic       mem_we,
  input  logic [4:0] mem_adr,
  input  logic       wb_we,
  input  logic [4:0] wb_adr,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (stage_hit(ex_we, ex_adr, rd_adr))
      sel = FWD_EX;
    else if (stage_hit(mem_we, mem_adr, rd_adr))
      sel = FWD_MEM;
    else if (stage_hit(wb_we, wb_adr, rd_adr))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_redirect_controller.sv
// Pipeline sequencer: forwarding selects, load-use stall, redirect flush, halt drain.
// Control outputs are same-cycle combinational; Halted and counters are registered.
module hazard_redirect_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  hazard_redirect_controller_if.slave  bus
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYC - 1);

  ctrl_state_t      state;
  logic [1:0]       drain_cnt;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       r1_sel;
  logic [1:0]       r2_sel;
  logic             load_use;
  logic             redirect_take;
  logic             stall;
  logic             flush_if_id;
  logic             flush_id_ex;

  fwd_select u_fwd_rs (
    .rd_adr (bus.R1Adr),
    .ex_we  (bus.EX_RegWrite),  .ex_adr (bus.EX_WAdr),
    .mem_we (bus.MEM_RegWrite), .mem_adr(bus.MEM_WAdr),
    .wb_we  (bus.WB_RegWrite),  .wb_adr (bus.WB_WAdr),
    .sel    (r1_sel)
  );

  fwd_select u_fwd_rt (
    .rd_adr (bus.R2Adr),
    .ex_we  (bus.EX_RegWrite),  .ex_adr (bus.EX_WAdr),
    .mem_we (bus.MEM_RegWrite), .mem_adr(bus.MEM_WAdr),
    .wb_we  (bus.WB_RegWrite),  .wb_adr (bus.WB_WAdr),
    .sel    (r2_sel)
  );

  assign load_use = bus.EX_MemRead && bus.EX_RegWrite && (bus.EX_WAdr != 5'd0) &&
                    ((bus.R1Used && (bus.R1Adr == bus.EX_WAdr)) ||
                     (bus.R2Used && (bus.R2Adr == bus.EX_WAdr)));

  // A halted pipeline has nothing older in flight, so a redirect there is stale.
  assign redirect_take = !RST && bus.Redirect && ((state == RUN) || (state == DRAIN));

  always_comb begin
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (redirect_take) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (!RST) begin
      case (state)
        RUN: begin
          if (load_use || bus.Halt) begin
            stall       = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        DRAIN, HALTED: begin
          stall       = 1'b1;
          flush_id_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted_q  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          // A load-use stall outranks the halt; the halt is retried once the load moves on.
          if (!bus.Redirect && !load_use && bus.Halt) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (bus.Redirect) begin
            state <= RUN;
          end else if (drain_cnt == 2'd0) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        HALTED: begin
          if (bus.Go) begin
            state    <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase

      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_take && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.R1_Fwd      = RST ? FWD_RF : r1_sel;
  assign bus.R2_Fwd      = RST ? FWD_RF : r2_sel;
  assign bus.Stall_PC_ID = stall;
  assign bus.Flush_IF_ID = flush_if_id;
  assign bus.Flush_ID_EX = flush_id_ex;
  assign bus.Halted      = halted_q;
  assign bus.StallCnt    = stall_cnt;
  assign bus.FlushCnt    = flush_cnt;

endmodule

// File: tb/tb_hazard_redirect_controller.sv
// Scoreboarded bench for hazard_redirect_controller; a 4-bit counter build shares the stimulus.
module tb_hazard_redirect_controller;

  typedef struct packed {
    logic [4:0] r1a; logic [4:0] r2a; logic r1u; logic r2u;
    logic [4:0] exa; logic exw; logic exm;
    logic [4:0] mema; logic memw;
    logic [4:0] wba; logic wbw;
    logic redir; logic halt; logic go;
  } stim_t;

  typedef struct packed {
    logic [1:0] r1; logic [1:0] r2;
    logic st; logic fif; logic fie; logic hl;
  } ctl_t;

  typedef struct packed {
    logic [1:0] r1; logic [1:0] r2;
    logic st; logic fif; logic fie; logic hl;
    logic [31:0] sc; logic [31:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_redirect_controller_if #(.CNT_W(32)) bus ();
  hazard_redirect_controller_if #(.CNT_W(4))  sbus ();

  hazard_redirect_controller #(.CNT_W(32), .DRAIN_CYC(3)) dut (
    .CLK(clk), .RST(rst), .bus(bus.slave)
  );

  hazard_redirect_controller #(.CNT_W(4), .DRAIN_CYC(3)) dut_small (
    .CLK(clk), .RST(rst), .bus(sbus.slave)
  );

  assign sbus.R1Adr        = bus.R1Adr;
  assign sbus.R2Adr        = bus.R2Adr;
  assign sbus.R1Used       = bus.R1Used;
  assign sbus.R2Used       = bus.R2Used;
  assign sbus.EX_WAdr      = bus.EX_WAdr;
  assign sbus.EX_RegWrite  = bus.EX_RegWrite;
  assign sbus.EX_MemRead   = bus.EX_MemRead;
  assign sbus.MEM_WAdr     = bus.MEM_WAdr;
  assign sbus.MEM_RegWrite = bus.MEM_RegWrite;
  assign sbus.WB_WAdr      = bus.WB_WAdr;
  assign sbus.WB_RegWrite  = bus.WB_RegWrite;
  assign sbus.Redirect     = bus.Redirect;
  assign sbus.Halt         = bus.Halt;
  assign sbus.Go           = bus.Go;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_sc;
  logic [31:0] m_fc;
  logic [3:0]  ms_sc;
  obs_t        exp_q[$];

  task automatic apply(input stim_t s);
    bus.R1Adr = s.r1a;  bus.R2Adr = s.r2a;  bus.R1Used = s.r1u;  bus.R2Used = s.r2u;
    bus.EX_WAdr = s.exa;  bus.EX_RegWrite = s.exw;  bus.EX_MemRead = s.exm;
    bus.MEM_WAdr = s.mema;  bus.MEM_RegWrite = s.memw;
    bus.WB_WAdr = s.wba;  bus.WB_RegWrite = s.wbw;
    bus.Redirect = s.redir;  bus.Halt = s.halt;  bus.Go = s.go;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk_exp(input ctl_t c);
    obs_t e;
    e.r1 = c.r1;  e.r2 = c.r2;  e.st = c.st;  e.fif = c.fif;  e.fie = c.fie;  e.hl = c.hl;
    e.sc = m_sc;  e.fc = m_fc;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.r1 = bus.R1_Fwd;  o.r2 = bus.R2_Fwd;  o.st = bus.Stall_PC_ID;
    o.fif = bus.Flush_IF_ID;  o.fie = bus.Flush_ID_EX;  o.hl = bus.Halted;
    o.sc = bus.StallCnt;  o.fc = bus.FlushCnt;
    return o;
  endfunction

  task automatic test_reset();
    stim_t s; ctl_t c; obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      s = '0; c = '0;
      if (i == 0) begin
        rst = 1'b1;
        s.exw = 1; s.exm = 1; s.exa = 5'd3; s.r1a = 5'd3; s.r1u = 1; s.r2a = 5'd3;
        s.halt = 1; s.redir = 1;
      end else begin
        rst = 1'b0;
      end
      apply(s);
      exp_q.push_back(mk_exp(c));
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got %h required %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_forward();
    stim_t s; ctl_t c; obs_t got, want;
    for (int i = 0; i < 7; i++) begin
      s = '0; c = '0;
      case (i)
        0: begin s.exw = 1; s.memw = 1; s.wbw = 1; s.exa = 5; s.mema = 5; s.wba = 5;
                 s.r1a = 5; s.r2a = 5; c.r1 = 2'd1; c.r2 = 2'd1; end
        1: begin s.memw = 1; s.wbw = 1; s.exa = 5; s.mema = 5; s.wba = 5;
                 s.r1a = 5; s.r2a = 5; c.r1 = 2'd2; c.r2 = 2'd2; end
        2: begin s.wbw = 1; s.exa = 5; s.mema = 5; s.wba = 5;
                 s.r1a = 5; s.r2a = 5; c.r1 = 2'd3; c.r2 = 2'd3; end
        3: begin s.exa = 5; s.mema = 5; s.wba = 5; s.r1a = 5; s.r2a = 5; end
        4: begin s.exw = 1; s.memw = 1; s.wbw = 1; s.exa = 5; s.mema = 5; s.wba = 5;
                 s.r1a = 5; s.r2a = 0; c.r1 = 2'd1; c.r2 = 2'd0; end
        5: begin s.exw = 1; s.memw = 1; s.wbw = 1; s.r1u = 1; s.r2u = 1; end
        6: begin s.exw = 1; s.exa = 7; s.memw = 1; s.mema = 5; s.wbw = 1; s.wba = 6;
                 s.r1a = 6; s.r2a = 5; c.r1 = 2'd3; c.r2 = 2'd2; end
        default: ;
      endcase
      apply(s);
      exp_q.push_back(mk_exp(c));
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL forward[%0d]: got %h required %h", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    stim_t s; ctl_t c; obs_t got, want;
    for (int i = 0; i < 5; i++) begin
      s = '0; c = '0;
      case (i)
        0: begin s.exm = 1; s.exw = 1; s.exa = 8; s.r1a = 8; s.r1u = 1;
                 c.r1 = 2'd1; c.st = 1; c.fie = 1; end
        1: begin s.memw = 1; s.mema = 8; s.r1a = 8; s.r1u = 1; c.r1 = 2'd2; end
        2: begin s.exm = 1; s.exw = 1; s.exa = 9; s.r2a = 9; s.r2u = 0; s.r1a = 4; s.r1u = 1;
                 c.r2 = 2'd1; end
        3: begin s.exm = 1; s.exw = 1; s.exa = 9; s.r2a = 9; s.r2u = 1;
                 c.r2 = 2'd1; c.st = 1; c.fie = 1; end
        4: begin s.exm = 1; s.exw = 1; s.exa = 0; s.r1a = 0; s.r1u = 1; end
        default: ;
      endcase
      apply(s);
      exp_q.push_back(mk_exp(c));
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use[%0d]: got %h required %h", i, got, want);
      end
      if (c.st) m_sc++;
      if (c.fif) m_fc++;
      tick();
    end
  endtask

  task automatic test_redirect();
    stim_t s; ctl_t c; obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      s = '0; c = '0;
      if (i == 0) begin
        s.redir = 1; s.halt = 1; s.exm = 1; s.exw = 1; s.exa = 3; s.r1a = 3; s.r1u = 1;
        c.r1 = 2'd1; c.fif = 1; c.fie = 1;
      end
      apply(s);
      exp_q.push_back(mk_exp(c));
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL redirect[%0d]: got %h required %h", i, got, want);
      end
      if (c.st) m_sc++;
      if (c.fif) m_fc++;
      tick();
    end
  endtask

  task automatic test_halt_drain();
    stim_t s; ctl_t c; obs_t got, want;
    logic [31:0] sc0;
    sc0 = m_sc;
    for (int i = 0; i < 10; i++) begin
      s = '0; c = '0;
      if (i < 9) begin c.st = 1; c.fie = 1; end
      if (i >= 4 && i < 9) c.hl = 1;
      if (i == 0) s.halt = 1;
      if (i == 1) s.go = 1;
      if (i == 5) s.redir = 1;
      if (i == 8) s.go = 1;
      apply(s);
      exp_q.push_back(mk_exp(c));
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL halt_drain[%0d]: got %h required %h", i, got, want);
      end
      if (i == 9) begin
        checks++;
        if (got.sc !== sc0 + 32'd9) begin
          errors++;
          $display("FAIL halt_stall_count: got %0d required %0d", got.sc, sc0 + 32'd9);
        end
      end
      if (c.st) m_sc++;
      if (c.fif) m_fc++;
      tick();
    end
  endtask

  task automatic test_drain_redirect();
    stim_t s; ctl_t c; obs_t got, want;
    for (int i = 0; i < 7; i++) begin
      s = '0; c = '0;
      case (i)
        0: begin s.halt = 1; c.st = 1; c.fie = 1; end
        1: begin c.st = 1; c.fie = 1; end
        2: begin s.redir = 1; c.fif = 1; c.fie = 1; end
        default: ;
      endcase
      apply(s);
      exp_q.push_back(mk_exp(c));
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL drain_redirect[%0d]: got %h required %h", i, got, want);
      end
      if (c.st) m_sc++;
      if (c.fif) m_fc++;
      tick();
    end
  endtask

  task automatic test_saturation();
    stim_t s; ctl_t c; obs_t got, want;
    logic [3:0] small_want;
    rst = 1'b1;
    apply('0);
    tick();
    rst = 1'b0;
    m_sc = '0; m_fc = '0; ms_sc = '0;
    for (int i = 0; i < 18; i++) begin
      s = '0; c = '0;
      c.st = 1; c.fie = 1;
      if (i >= 4) c.hl = 1;
      if (i == 0) s.halt = 1;
      if (i == 17) s.go = 1;
      apply(s);
      exp_q.push_back(mk_exp(c));
      small_want = ms_sc;
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL saturation_main[%0d]: got %h required %h", i, got, want);
      end
      checks++;
      if (sbus.StallCnt !== small_want) begin
        errors++;
        $display("FAIL saturation_small[%0d]: got %h required %h", i, sbus.StallCnt, small_want);
      end
      if (c.st) m_sc++;
      if (c.st && ms_sc != 4'hF) ms_sc++;
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    stim_t s; ctl_t c; obs_t got, want;
    for (int i = 0; i < 6; i++) begin
      s = '0; c = '0;
      rst = 1'b0;
      case (i)
        1: begin s.halt = 1; c.st = 1; c.fie = 1; end
        2: begin c.st = 1; c.fie = 1; end
        3: begin rst = 1'b1; s.exw = 1; s.exa = 3; s.r1a = 3; s.r2a = 3; s.halt = 1; end
        default: ;
      endcase
      apply(s);
      exp_q.push_back(mk_exp(c));
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_drain[%0d]: got %h required %h", i, got, want);
      end
      if (i >= 4) begin
        checks++;
        if (sbus.StallCnt !== 4'h0 || sbus.Halted !== 1'b0) begin
          errors++;
          $display("FAIL reset_small[%0d]: got cnt %h halted %b required 0 0", i, sbus.StallCnt, sbus.Halted);
        end
      end
      if (c.st) m_sc++;
      tick();
      if (i == 3) begin
        m_sc = '0; m_fc = '0; ms_sc = '0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    apply('0);
    m_sc = '0; m_fc = '0; ms_sc = '0;
    tick();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_halt_drain();
    test_drain_redirect();
    test_saturation();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
